demorgan_1st_b: RTL and testbench

- Bitwise De Morgan "first law, B side" evaluator: e = ~a | ~b, the NAND function built from inverted inputs.
- Provides a combinational result for purely combinational use.
- Provides a registered, valid-qualified copy and a saturating count of accepted vectors.
- Leaf block in the lab logic-primitives set; used standalone or as a checked reference for NAND-form logic.

---
 rtl/demorgan_pkg.sv | 15 +
 rtl/demorgan_1st_b_sat_counter.sv | 25 ++
 rtl/demorgan_1st_b.sv | 87 ++++++++
 tb/tb_demorgan_1st_b.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demorgan_pkg.sv
// demorgan_pkg
//   Shared constants and helpers for the demorgan_1st_b primitive.
//   DEF_WIDTH  : default lane count of the evaluator.
//   DEF_CNT_W  : default width of the accepted-vector counter.
//   nand_form  : single-lane ~a | ~b. Callers apply it per lane.
package demorgan_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    function automatic logic nand_form(input logic a, input logic b);
        return ~a | ~b;
    endfunction

endpackage

// File: rtl/demorgan_1st_b_sat_counter.sv
// demorgan_1st_b_sat_counter
//   Up-counter that increments on each enabled cycle and sticks at all-ones.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset, clears the count
//     en     : count this cycle
//     cnt    : current count, CNT_W bits
module demorgan_1st_b_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demorgan_1st_b.sv
// demorgan_1st_b
//   Bitwise De Morgan evaluator, B side: e = ~a | ~b.
//   A combinational result, a registered valid-qualified copy and a
//   saturating count of accepted vectors.
//   Optional build macro DEMORGAN_CHECK_EN: also forms ~(a & b) and raises
//   a sticky chk_err if it ever disagrees with ~a | ~b on an accepted vector.
//   Without the macro chk_err is tied 0.
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset
//     a, b      : operands, WIDTH bits
//     in_valid  : qualifies a/b for the registered path
//     e         : combinational ~a | ~b
//     e_q       : registered result (holds while in_valid is low)
//     out_valid : e_q was captured on the last edge
//     vec_cnt   : accepted-vector count, saturating at all-ones
//     chk_err   : sticky equivalence-mismatch flag
module demorgan_1st_b
    import demorgan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] e_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] vec_cnt,
    output logic             chk_err
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign e[i] = nand_form(a[i], b[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                e_q <= e;
            end
        end
    end

    demorgan_1st_b_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .cnt   (vec_cnt)
    );

`ifdef DEMORGAN_CHECK_EN
    logic [WIDTH-1:0] lhs_form;
    logic             lane_mismatch;

    assign lhs_form      = ~(a & b);
    assign lane_mismatch = |(lhs_form ^ e);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (in_valid && lane_mismatch) begin
            chk_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && in_valid && lane_mismatch && !chk_err) begin
            $error("demorgan_1st_b: ~(a&b) != ~a|~b, a=%b b=%b", a, b);
        end
    end
`endif
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_demorgan_1st_b.sv
module tb_demorgan_1st_b;

    logic clk;
    logic rst_n;

    // dut0: default build, WIDTH=1 CNT_W=16
    logic        a0, b0, v0;
    logic        e0, eq0, ov0, chk0;
    logic [15:0] cnt0;

    // dut1: saturation check, CNT_W=3
    logic        a1, b1, v1;
    logic        e1, eq1, ov1, chk1;
    logic [2:0]  cnt1;

    // dut2: WIDTH=4 lanes
    logic [3:0]  a2, b2, e2, eq2;
    logic        v2, ov2, chk2;
    logic [15:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    logic        q0[$];
    logic [3:0]  q2[$];
    logic        last_eq0;
    logic [15:0] cnt_exp0;

    demorgan_1st_b #(.WIDTH(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .in_valid(v0),
        .e(e0), .e_q(eq0), .out_valid(ov0), .vec_cnt(cnt0), .chk_err(chk0));

    demorgan_1st_b #(.WIDTH(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
        .e(e1), .e_q(eq1), .out_valid(ov1), .vec_cnt(cnt1), .chk_err(chk1));

    demorgan_1st_b #(.WIDTH(4), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .in_valid(v2),
        .e(e2), .e_q(eq2), .out_valid(ov2), .vec_cnt(cnt2), .chk_err(chk2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_model();
        q0.delete();
        q2.delete();
        last_eq0 = 1'b0;
        cnt_exp0 = '0;
    endtask

    // One dut0 cycle: drive, push expectation, take the edge, compare.
    task automatic step0(input logic aa, input logic bb, input logic vv);
        a0 = aa; b0 = bb; v0 = vv;
        if (vv) begin
            q0.push_back(~(aa & bb));
            if (cnt_exp0 != 16'hffff) cnt_exp0 = cnt_exp0 + 16'd1;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ov0 !== vv) begin
            n_err++; $display("FAIL out_valid: got %b want %b", ov0, vv);
        end
        if (ov0 === 1'b1) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++; $display("FAIL scoreboard_empty: out_valid=1 with nothing pending");
            end else begin
                last_eq0 = q0.pop_front();
                if (eq0 !== last_eq0) begin
                    n_err++; $display("FAIL e_q: got %b want %b", eq0, last_eq0);
                end
            end
        end else begin
            n_cmp++;
            if (eq0 !== last_eq0) begin
                n_err++; $display("FAIL e_q_hold: got %b want %b", eq0, last_eq0);
            end
        end
        n_cmp++;
        if (cnt0 !== cnt_exp0) begin
            n_err++; $display("FAIL vec_cnt: got %0d want %0d", cnt0, cnt_exp0);
        end
        n_cmp++;
        if (e0 !== ~(aa & bb)) begin
            n_err++; $display("FAIL e_comb: got %b want %b", e0, ~(aa & bb));
        end
    endtask

    task automatic check_cleared(input string tag);
        n_cmp++;
        if (eq0 !== 1'b0 || ov0 !== 1'b0 || cnt0 !== 16'd0 || chk0 !== 1'b0 ||
            cnt1 !== 3'd0 || ov1 !== 1'b0 || eq2 !== 4'd0 || cnt2 !== 16'd0) begin
            n_err++;
            $display("FAIL %s: e_q=%b ov=%b cnt=%0d chk=%b cnt1=%0d ov1=%b eq2=%b cnt2=%0d want all 0",
                     tag, eq0, ov0, cnt0, chk0, cnt1, ov1, eq2, cnt2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a0 = 0; b0 = 0; v0 = 0;
        a1 = 0; b1 = 0; v1 = 0;
        a2 = '0; b2 = '0; v2 = 0;
        clear_model();
        #12;
        check_cleared("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_toggle();
        // (a,b) = 00,10,01,11 repeating, 50 ns windows over 1000 ns
        for (int i = 0; i < 20; i++) begin
            a0 = i[0];
            b0 = i[1];
            #25;
            n_cmp++;
            if (e0 !== ((i % 4 == 3) ? 1'b0 : 1'b1)) begin
                n_err++; $display("FAIL toggle_e[%0d]: a=%b b=%b got %b", i, a0, b0, e0);
            end
            #25;
        end
        n_cmp++;
        if (cnt0 !== 16'd0 || ov0 !== 1'b0) begin
            n_err++; $display("FAIL toggle_idle: cnt=%0d ov=%b want 0 0", cnt0, ov0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_registered();
        step0(1'b1, 1'b1, 1'b1);
        step0(1'b0, 1'b1, 1'b1);
        step0(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (cnt0 !== 16'd2 || eq0 !== 1'b1) begin
            n_err++; $display("FAIL registered_final: cnt=%0d e_q=%b want 2 1", cnt0, eq0);
        end
    endtask

    task automatic test_valid_gating();
        step0(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step0(i[0], i[1], 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            step0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end
        step0(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 1; i <= 10; i++) begin
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            v1 = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (cnt1 !== 3'((i > 7) ? 7 : i)) begin
                n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, cnt1, (i > 7) ? 7 : i);
            end
        end
        v1 = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cnt1 !== 3'd7 || ov1 !== 1'b0) begin
            n_err++; $display("FAIL sat_hold: cnt=%0d ov=%b want 7 0", cnt1, ov1);
        end
    endtask

    task automatic test_width4();
        a2 = 4'b1100; b2 = 4'b1010;
        #1;
        n_cmp++;
        if (e2 !== 4'b0111) begin
            n_err++; $display("FAIL w4_e: got %b want 0111", e2);
        end
        for (int i = 0; i < 256; i++) begin
            a2 = i[7:4];
            b2 = i[3:0];
            v2 = 1'b1;
            q2.push_back(~(i[7:4] & i[3:0]));
            #1;
            n_cmp++;
            if (e2 !== ~(a2 & b2)) begin
                n_err++; $display("FAIL w4_comb: a=%b b=%b got %b", a2, b2, e2);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (ov2 !== 1'b1 || q2.size() == 0) begin
                n_err++; $display("FAIL w4_valid: ov=%b pending=%0d", ov2, q2.size());
            end else begin
                logic [3:0] exp_q;
                exp_q = q2.pop_front();
                if (eq2 !== exp_q) begin
                    n_err++; $display("FAIL w4_e_q: got %b want %b", eq2, exp_q);
                end
            end
            n_cmp++;
            if (chk2 !== 1'b0) begin
                n_err++; $display("FAIL w4_chk_err: got %b want 0", chk2);
            end
        end
        v2 = 1'b0;
        n_cmp++;
        if (cnt2 !== 16'd256) begin
            n_err++; $display("FAIL w4_cnt: got %0d want 256", cnt2);
        end
    endtask

    task automatic test_async_reset();
        step0(1'b1, 1'b0, 1'b1);
        step0(1'b1, 1'b1, 1'b1);
        v0 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        a0 = 1'b1; b0 = 1'b1;
        #1;
        n_cmp++;
        if (e0 !== 1'b0) begin
            n_err++; $display("FAIL reset_e_11: got %b want 0", e0);
        end
        a0 = 1'b0;
        #1;
        n_cmp++;
        if (e0 !== 1'b1) begin
            n_err++; $display("FAIL reset_e_01: got %b want 1", e0);
        end
        @(posedge clk); #1;
        check_cleared("reset_held");
        rst_n = 1'b1;
        clear_model();
        step0(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_registered();
        test_valid_gating();
        test_back_to_back();
        test_saturation();
        test_width4();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
